// File: rtl/tff_counter_ctrl_pkg.sv
// Shared types and next-count arithmetic for T-FF based modulo counters.
package tff_counter_ctrl_pkg;

  // Operation selected by the priority decode (load > en > hold).
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    LOAD = 2'd3
  } mode_e;

  // Next count for a modulo counter, computed on 32-bit values.
  // The caller truncates the result to its own width.
  // An illegal current value (>= modulus) counting up goes straight to 0,
  // so the counter cannot get stuck outside its range.
  function automatic logic [31:0] next_count(input mode_e mode,
                                             input logic [31:0] q,
                                             input logic [31:0] din,
                                             input logic [31:0] modulus);
    logic [31:0] res;
    res = q;
    case (mode)
      LOAD:    res = (din < modulus) ? din : 32'd0;
      UP:      res = (q >= modulus - 32'd1) ? 32'd0 : q + 32'd1;
      DOWN:    res = (q == 32'd0) ? modulus - 32'd1 : q - 32'd1;
      default: res = q;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop with complementary outputs and async active-low reset.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic qb
);

  // Invert on a rising edge when t is high; clear immediately on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= 1'b0;
    else if (t) q <= ~q;
  end

  assign qb = ~q;

endmodule

// File: rtl/tff_counter_ctrl.sv
// Modulo-N up/down counter with parallel load, built from a bank of T
// flip-flops. The controller only decodes the next count and turns it into a
// toggle vector; every state bit lives in a tff_cell.
// MODULUS is expected to satisfy 2 <= MODULUS <= 2**WIDTH, WIDTH < 32.
module tff_counter_ctrl
  import tff_counter_ctrl_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_vec,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  mode_e            mode;
  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] qb_bank;
  logic             is_zero;
  logic             is_max;

  // Priority decode: load beats count enable, otherwise hold.
  always_comb begin
    mode = HOLD;
    if (load)    mode = LOAD;
    else if (en) mode = up ? UP : DOWN;
  end

  // Next count and the toggle vector that moves the bank to it.
  // Under reset the bank is being cleared, so no toggles are requested.
  always_comb begin
    q_n   = WIDTH'(next_count(mode, 32'(q), 32'(din), 32'(MODULUS)));
    t_vec = rst ? (q ^ q_n) : '0;
  end

  // Zero detect uses the complementary outputs of the bank directly.
  assign is_zero = &qb_bank;
  assign is_max  = (q == MAX_VAL);

  // Carry out for cascading: high in the cycle whose closing edge wraps.
  assign tc = rst & en & ~load & ((up & is_max) | (~up & is_zero));

  // One T flip-flop per count bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bank
    tff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (t_vec[i]),
      .q   (q[i]),
      .qb  (qb_bank[i])
    );
  end

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Directed bench for tff_counter_ctrl (WIDTH=4, MODULUS=10) plus a two-stage
// BCD cascade.
module tb_tff_counter_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] din;
  logic [3:0] q;
  logic [3:0] t_vec;
  logic       tc;

  // cascade stages
  logic       c_en0;
  logic [3:0] c_q0, c_q1, c_t0, c_t1;
  logic       c_tc0, c_tc1;

  int errors;
  int checks;

  tff_counter_ctrl #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .q(q), .t_vec(t_vec), .tc(tc)
  );

  tff_counter_ctrl #(.WIDTH(4), .MODULUS(10)) u_stage0 (
    .clk(clk), .rst(rst), .en(c_en0), .up(1'b1), .load(1'b0), .din(4'd0),
    .q(c_q0), .t_vec(c_t0), .tc(c_tc0)
  );

  tff_counter_ctrl #(.WIDTH(4), .MODULUS(10)) u_stage1 (
    .clk(clk), .rst(rst), .en(c_tc0), .up(1'b1), .load(1'b0), .din(4'd0),
    .q(c_q1), .t_vec(c_t1), .tc(c_tc1)
  );

  // clock: rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // advance past the next rising edge; outputs are sampled mid-cycle
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int exp_q;
    int exp_n;
    errors = 0;
    checks = 0;
    rst   = 1'b0;
    en    = 1'b0;
    up    = 1'b1;
    load  = 1'b0;
    din   = 4'd0;
    c_en0 = 1'b0;
    #2;
    check("reset_q", 32'(q), 0);
    check("reset_tvec", 32'(t_vec), 0);
    check("reset_tc", 32'(tc), 0);

    // release reset between edges, load 6, then count
    #5;
    rst = 1'b1;
    load = 1'b1;
    din = 4'd6;
    tick();
    load = 1'b0;
    check("load6_q", 32'(q), 6);
    en = 1'b1;
    up = 1'b1;
    #1;
    check("pre_reset_tvec", 32'(t_vec), 32'(4'b0001));

    // asynchronous reset mid-cycle
    rst = 1'b0;
    #1;
    check("async_reset_q", 32'(q), 0);
    check("async_reset_tvec", 32'(t_vec), 0);
    check("async_reset_tc", 32'(tc), 0);
    tick();
    check("reset_held_q", 32'(q), 0);
    en = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_after_release_q", 32'(q), 0);
      check("hold_tvec", 32'(t_vec), 0);
    end

    // up-count 0..9 then wrap to 0
    en = 1'b1;
    up = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      exp_q = i;
      exp_n = (i == 9) ? 0 : i + 1;
      check("up_q", 32'(q), 32'(exp_q));
      check("up_tc", 32'(tc), (i == 9) ? 1 : 0);
      check("up_tvec", 32'(t_vec), 32'(exp_q ^ exp_n));
      tick();
    end
    check("up_wrap_q", 32'(q), 0);

    // down-count 1, 0, 9, 8
    en = 1'b0;
    load = 1'b1;
    din = 4'd1;
    tick();
    load = 1'b0;
    en = 1'b1;
    up = 1'b0;
    #1;
    check("down_q1", 32'(q), 1);
    check("down_tc1", 32'(tc), 0);
    check("down_tvec1", 32'(t_vec), 32'(4'b0001));
    tick();
    check("down_q0", 32'(q), 0);
    check("down_tc0", 32'(tc), 1);
    check("down_tvec0", 32'(t_vec), 32'(4'b1001));
    tick();
    check("down_q9", 32'(q), 9);
    check("down_tc9", 32'(tc), 0);
    check("down_tvec9", 32'(t_vec), 32'(4'b0001));
    // direction change takes effect on the very next edge
    up = 1'b1;
    #1;
    check("dir_change_tc", 32'(tc), 1);
    check("dir_change_tvec", 32'(t_vec), 32'(4'b1001));
    tick();
    check("dir_change_q", 32'(q), 0);

    // load priority over count
    en = 1'b0;
    load = 1'b1;
    din = 4'd3;
    tick();
    check("load3_q", 32'(q), 3);
    en = 1'b1;
    up = 1'b1;
    din = 4'd7;
    #1;
    check("loadprio_tvec", 32'(t_vec), 32'(4'b0100));
    check("loadprio_tc", 32'(tc), 0);
    tick();
    check("loadprio_q", 32'(q), 7);
    din = 4'd12;
    #1;
    check("load_oor_tvec", 32'(t_vec), 32'(4'b0111));
    tick();
    check("load_oor_q", 32'(q), 0);
    din = 4'd9;
    tick();
    check("load9_q", 32'(q), 9);
    // at q = 9 with en and up, load still suppresses tc
    #1;
    check("load_at_max_tc", 32'(tc), 0);
    check("load_at_max_tvec", 32'(t_vec), 0);
    load = 1'b0;
    en = 1'b0;
    din = 4'd5;
    #1;
    check("hold_at9_tvec", 32'(t_vec), 0);
    check("hold_at9_tc", 32'(tc), 0);
    tick();
    check("hold_at9_q", 32'(q), 9);

    // two-stage BCD cascade, 25 increments from 00
    c_en0 = 1'b1;
    #1;
    check("casc_start_q0", 32'(c_q0), 0);
    check("casc_start_q1", 32'(c_q1), 0);
    for (int i = 1; i <= 25; i++) begin
      tick();
      check("casc_q0", 32'(c_q0), 32'(i % 10));
      check("casc_q1", 32'(c_q1), 32'(i / 10));
    end
    c_en0 = 1'b0;
    tick();
    check("casc_final_q1", 32'(c_q1), 2);
    check("casc_final_q0", 32'(c_q0), 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tff_counter_ctrl.md
# tff_counter_ctrl

Toggle-sequencing controller for a bank of T flip-flops, forming a synchronous modulo-N up/down counter with parallel load. Each cycle it computes the per-bit toggle vector for the T-FF bank from the current count and the requested operation. It is the standard way this codebase builds counters on top of the T flip-flop primitive. It also serves as a cascadable decade stage (BCD) for multi-digit counters.

## Interface

Parameters:
- WIDTH, 4, bit width of the count and of the T-FF bank.
- MODULUS, 10, count range 0..MODULUS-1; legal range 2 ≤ MODULUS ≤ 2^WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (rst = 0 resets).
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en = 1.
- load  input  1  parallel load request; has priority over en.
- din  input  WIDTH  load value.
- q  output  WIDTH  current count, taken from the T-FF bank.
- t_vec  output  WIDTH  toggle vector currently applied to the bank (combinational).
- tc  output  1  terminal-count / carry for cascading (combinational).

## Operation

- One storage element per bit: a T flip-flop. On each rising clk edge, bit i of q inverts iff t_vec[i] = 1.
- The controller first computes the next count q_n, then sets t_vec = q ^ q_n. No D-path bypasses the T-FF bank.
- Priority, evaluated each cycle:
  - load = 1: q_n = din if din < MODULUS; otherwise q_n = 0 (out-of-range loads are forced to 0). The up and en inputs are ignored.
  - load = 0, en = 1, up = 1: q_n = 0 if q == MODULUS-1, else q+1.
  - load = 0, en = 1, up = 0: q_n = MODULUS-1 if q == 0, else q-1.
  - load = 0, en = 0: q_n = q, so t_vec = 0 (hold).
- If q ever holds an illegal value (≥ MODULUS), the next enabled up-count goes to 0 and the next down-count goes to q-1. The counter must never lock up.
- Increment and decrement arithmetic is WIDTH bits wide, with no carry out beyond the wrap rule.
- tc = en & ~load & ((up & q == MODULUS-1) | (~up & q == 0)). This is high during the cycle whose closing edge wraps the count.
- Cascading: tc of stage k drives en of stage k+1, and all stages share clk and rst.

## Timing

- Reset: while rst = 0, q = 0 immediately (asynchronous), tc = 0, and t_vec = 0 (because en and load are don't-care under reset, t_vec is forced to 0).
- Reset release: the first active edge is the first clk rising edge at which rst = 1. Deassertion is assumed synchronous to clk upstream.
- Latency: a load or count request present before edge n is visible on q right after edge n (1 cycle).
- t_vec and tc are combinational from q, en, up, load and din. They are valid within the same cycle and have no registered delay.
- Simultaneous load and en: load wins, and tc = 0 in that cycle.
- Reset mid-operation: q clears asynchronously, regardless of any pending load or en. After release, counting resumes from 0.
- Direction change takes effect on the next edge. There is no dead cycle.

## Structure

- Shared package (e.g. counter_pkg): a localparam function computing next-count by mode, plus a mode encoding typedef (HOLD, UP, DOWN, LOAD) used by the priority decode.
- Sub-module: tff_cell, a single T flip-flop with q and qb outputs, T input, clk and active-low asynchronous rst. It is instantiated WIDTH times via a generate loop.
- The controller logic is purely next-state and toggle decode; all state lives in the tff_cell instances.

## Test plan

- Reset and hold: assert rst = 0 mid-count with q = 6 → q = 0 immediately, t_vec = 0, tc = 0. Release with en = 0 for 3 cycles → q stays 0.
- Up-count wrap (WIDTH = 4, MODULUS = 10): en = 1, up = 1 from 0 for 10 edges → q steps 0..9 then 0. tc = 1 only while q = 9; t_vec = 4'b1001 at the 9→0 edge.
- Down-count wrap: en = 1, up = 0 from q = 1 → q goes 1, 0, 9, 8. tc = 1 only while q = 0; t_vec = 4'b1001 at the 0→9 edge.
- Load priority: q = 3, en = 1, up = 1, load = 1, din = 7 → q = 7 after one edge, t_vec = 4'b0100, tc = 0. Load with din = 12 → q = 0.
- Cascade: two stages with tc0 → en1, en0 = 1 for 25 edges from 00 → {q1, q0} = 2, 5. The stage-1 increment occurs only on the q0 9→0 edges.
